// File: rtl/sgdmac_pkg.sv
// Shared SGDMAC constants and width helpers, used by the FIFOs and the DMA engines.
package sgdmac_pkg;

  localparam int unsigned SgdmacNumCh      = 4;
  localparam int unsigned SgdmacFifoDepth  = 16;
  localparam int unsigned SgdmacDataWidth  = 32;

  // Channel index width; a single channel still gets a 1-bit select.
  function automatic int unsigned calc_ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int unsigned calc_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sgdmac_fifo_ch.sv
// One channel queue of the multi-channel FIFO: pointers, count, status, sticky errors, storage.
module sgdmac_fifo_ch
  import sgdmac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = SgdmacFifoDepth,
  parameter int unsigned DATA_WIDTH = SgdmacDataWidth,
  localparam int unsigned CNT_W     = calc_cnt_w(FIFO_DEPTH),
  localparam int unsigned AW        = CNT_W - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_i,
  input  logic                  rd_req_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [CNT_W-1:0]      afull_thr_i,
  input  logic [CNT_W-1:0]      aempty_thr_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  afull_o,
  output logic                  aempty_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  logic [CNT_W-1:0]      wrptr_q, wrptr_d;
  logic [CNT_W-1:0]      rdptr_q, rdptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic wr_acc, rd_acc;
  logic ovf_set, udf_set;

  // Acceptance uses this cycle's registered flags, so a same-cycle pop never frees a full slot.
  assign wr_acc  = wr_req_i & ~full_q  & ~flush_i;
  assign rd_acc  = rd_req_i & ~empty_q & ~flush_i;
  assign ovf_set = wr_req_i &  full_q  & ~flush_i;
  assign udf_set = rd_req_i &  empty_q & ~flush_i;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    if (flush_i) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wrptr_d = wrptr_q + CNT_W'(1);
      if (rd_acc) rdptr_d = rdptr_q + CNT_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    // A new error wins over a simultaneous clear.
    ovf_d   = (ovf_q & ~err_clr_i) | ovf_set;
    udf_d   = (udf_q & ~err_clr_i) | udf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem_q[wrptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign head_o   = mem_q[rdptr_q[AW-1:0]];
  assign cnt_o    = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign afull_o  = (count_q >= afull_thr_i);
  assign aempty_o = (count_q <= aempty_thr_i);
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule

// File: rtl/sgdmac_mc_fifo.sv
// Multi-channel SGDMAC FIFO: shared write/read ports steered to NUM_CH independent queues.
module sgdmac_mc_fifo
  import sgdmac_pkg::*;
#(
  parameter int unsigned NUM_CH     = SgdmacNumCh,
  parameter int unsigned FIFO_DEPTH = SgdmacFifoDepth,
  parameter int unsigned DATA_WIDTH = SgdmacDataWidth,
  localparam int unsigned CH_W      = calc_ch_w(NUM_CH),
  localparam int unsigned CNT_W     = calc_cnt_w(FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wren_i,
  input  logic [CH_W-1:0]         wr_ch_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    rden_i,
  input  logic [CH_W-1:0]         rd_ch_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic [NUM_CH-1:0]       flush_i,
  input  logic [CNT_W-1:0]        afull_thr_i,
  input  logic [CNT_W-1:0]        aempty_thr_i,
  input  logic                    err_clr_i,
  output logic [NUM_CH-1:0]       full_o,
  output logic [NUM_CH-1:0]       afull_o,
  output logic [NUM_CH-1:0]       empty_o,
  output logic [NUM_CH-1:0]       aempty_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic [NUM_CH-1:0]       udf_o,
  output logic [NUM_CH*CNT_W-1:0] cnt_o
);

  logic [DATA_WIDTH-1:0] head [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_req, rd_req;
    assign wr_req = wren_i & (wr_ch_i == CH_W'(c));
    assign rd_req = rden_i & (rd_ch_i == CH_W'(c));

    sgdmac_fifo_ch #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .wr_req_i     (wr_req),
      .rd_req_i     (rd_req),
      .flush_i      (flush_i[c]),
      .wdata_i      (wdata_i),
      .afull_thr_i  (afull_thr_i),
      .aempty_thr_i (aempty_thr_i),
      .err_clr_i    (err_clr_i),
      .head_o       (head[c]),
      .cnt_o        (cnt_o[c*CNT_W +: CNT_W]),
      .full_o       (full_o[c]),
      .empty_o      (empty_o[c]),
      .afull_o      (afull_o[c]),
      .aempty_o     (aempty_o[c]),
      .ovf_o        (ovf_o[c]),
      .udf_o        (udf_o[c])
    );
  end

  // Compare-based mux keeps out-of-range selects (non power-of-2 NUM_CH) at zero.
  always_comb begin
    rdata_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_i == CH_W'(c)) rdata_o = head[c];
    end
  end

endmodule

// File: tb/tb_sgdmac_mc_fifo.sv
// Directed self-checking bench for sgdmac_mc_fifo with default parameters.
module tb_sgdmac_mc_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren_i, rden_i, err_clr_i;
  logic [1:0]  wr_ch_i, rd_ch_i;
  logic [31:0] wdata_i, rdata_o;
  logic [3:0]  flush_i;
  logic [4:0]  afull_thr_i, aempty_thr_i;
  logic [3:0]  full_o, afull_o, empty_o, aempty_o, ovf_o, udf_o;
  logic [19:0] cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sgdmac_mc_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wren_i       (wren_i),
    .wr_ch_i      (wr_ch_i),
    .wdata_i      (wdata_i),
    .rden_i       (rden_i),
    .rd_ch_i      (rd_ch_i),
    .rdata_o      (rdata_o),
    .flush_i      (flush_i),
    .afull_thr_i  (afull_thr_i),
    .aempty_thr_i (aempty_thr_i),
    .err_clr_i    (err_clr_i),
    .full_o       (full_o),
    .afull_o      (afull_o),
    .empty_o      (empty_o),
    .aempty_o     (aempty_o),
    .ovf_o        (ovf_o),
    .udf_o        (udf_o),
    .cnt_o        (cnt_o)
  );

  function automatic logic [4:0] cnt_of(input int c);
    return cnt_o[c*5 +: 5];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] d);
    wren_i = 1'b1; wr_ch_i = ch; wdata_i = d;
    tick();
    wren_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ch);
    rden_i = 1'b1; rd_ch_i = ch;
    tick();
    rden_i = 1'b0;
  endtask

  task automatic clr_err();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++; if (empty_o !== 4'hF) begin n_fail++; $display("FAIL reset_empty: got %h want f", empty_o); end
    n_tests++; if (full_o !== 4'h0) begin n_fail++; $display("FAIL reset_full: got %h want 0", full_o); end
    n_tests++; if (cnt_o !== 20'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", cnt_o); end
    n_tests++; if ({ovf_o, udf_o} !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h want 00", {ovf_o, udf_o}); end
    n_tests++; if (aempty_o !== 4'hF) begin n_fail++; $display("FAIL reset_aempty: got %h want f", aempty_o); end
    n_tests++; if (afull_o !== 4'h0) begin n_fail++; $display("FAIL reset_afull16: got %h want 0", afull_o); end
    afull_thr_i = 5'd0;
    #1;
    n_tests++; if (afull_o !== 4'hF) begin n_fail++; $display("FAIL reset_afull0: got %h want f", afull_o); end
    afull_thr_i = 5'd16;
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) wr(2'd2, 32'h100 + i);
    n_tests++; if (full_o[2] !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full_o[2]); end
    n_tests++; if (cnt_of(2) !== 5'd16) begin n_fail++; $display("FAIL fill_cnt: got %0d want 16", cnt_of(2)); end
    wr(2'd2, 32'hDEAD);
    n_tests++; if (ovf_o !== 4'b0100) begin n_fail++; $display("FAIL fill_ovf: got %b want 0100", ovf_o); end
    n_tests++; if (cnt_of(2) !== 5'd16) begin n_fail++; $display("FAIL fill_cnt17: got %0d want 16", cnt_of(2)); end
    rd_ch_i = 2'd2;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (rdata_o !== 32'h100 + i) begin
        n_fail++; $display("FAIL fill_rdata[%0d]: got %h want %h", i, rdata_o, 32'h100 + i);
      end
      rd(2'd2);
    end
    n_tests++; if (empty_o[2] !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty_o[2]); end
    n_tests++; if (udf_o !== 4'b0000) begin n_fail++; $display("FAIL drain_udf0: got %b want 0000", udf_o); end
    rd(2'd2);
    n_tests++; if (udf_o !== 4'b0100) begin n_fail++; $display("FAIL drain_udf: got %b want 0100", udf_o); end
  endtask

  task automatic test_wrap();
    rd_ch_i = 2'd0;
    for (int i = 0; i < 24; i++) begin
      wr(2'd0, i);
      n_tests++;
      if (rdata_o !== 32'(i) || empty_o[0] !== 1'b0 || cnt_of(0) !== 5'd1 || full_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL wrap_wr[%0d]: got d=%h e=%b c=%0d f=%b want d=%h e=0 c=1 f=0",
                           i, rdata_o, empty_o[0], cnt_of(0), full_o[0], i);
      end
      rd(2'd0);
      n_tests++;
      if (empty_o[0] !== 1'b1 || cnt_of(0) !== 5'd0) begin
        n_fail++; $display("FAIL wrap_rd[%0d]: got e=%b c=%0d want e=1 c=0", i, empty_o[0], cnt_of(0));
      end
    end
    n_tests++; if (udf_o[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_udf: got %b want 0", udf_o[0]); end
  endtask

  task automatic test_back_to_back();
    clr_err();
    n_tests++; if ({ovf_o, udf_o} !== 8'h00) begin n_fail++; $display("FAIL clr_err: got %h want 00", {ovf_o, udf_o}); end
    for (int i = 0; i < 16; i++) wr(2'd1, 32'h200 + i);
    wren_i = 1'b1; wr_ch_i = 2'd1; wdata_i = 32'hBAD;
    rden_i = 1'b1; rd_ch_i = 2'd1;
    tick();
    wren_i = 1'b0; rden_i = 1'b0;
    n_tests++; if (ovf_o !== 4'b0010) begin n_fail++; $display("FAIL simfull_ovf: got %b want 0010", ovf_o); end
    n_tests++; if (cnt_of(1) !== 5'd15) begin n_fail++; $display("FAIL simfull_cnt: got %0d want 15", cnt_of(1)); end
    n_tests++; if (rdata_o !== 32'h201) begin n_fail++; $display("FAIL simfull_rdata: got %h want 201", rdata_o); end
    for (int i = 0; i < 15; i++) rd(2'd1);
    n_tests++; if (empty_o[1] !== 1'b1) begin n_fail++; $display("FAIL simfull_drain: got %b want 1", empty_o[1]); end
    wren_i = 1'b1; wr_ch_i = 2'd1; wdata_i = 32'h2AA;
    rden_i = 1'b1; rd_ch_i = 2'd1;
    tick();
    wren_i = 1'b0; rden_i = 1'b0;
    n_tests++; if (cnt_of(1) !== 5'd1) begin n_fail++; $display("FAIL simempty_cnt: got %0d want 1", cnt_of(1)); end
    n_tests++; if (udf_o !== 4'b0010) begin n_fail++; $display("FAIL simempty_udf: got %b want 0010", udf_o); end
    n_tests++; if (rdata_o !== 32'h2AA) begin n_fail++; $display("FAIL simempty_rdata: got %h want 2aa", rdata_o); end
  endtask

  task automatic test_thresholds();
    afull_thr_i = 5'd12; aempty_thr_i = 5'd3;
    #1;
    n_tests++; if (aempty_o[3] !== 1'b1 || afull_o[3] !== 1'b0) begin
      n_fail++; $display("FAIL thr_init: got af=%b ae=%b want af=0 ae=1", afull_o[3], aempty_o[3]);
    end
    for (int k = 1; k <= 12; k++) begin
      wr(2'd3, 32'h400 + k);
      n_tests++;
      if (afull_o[3] !== (k >= 12) || aempty_o[3] !== (k <= 3)) begin
        n_fail++; $display("FAIL thr_w%0d: got af=%b ae=%b want af=%b ae=%b",
                           k, afull_o[3], aempty_o[3], k >= 12, k <= 3);
      end
    end
    afull_thr_i = 5'd13;
    #1;
    n_tests++; if (afull_o[3] !== 1'b0) begin n_fail++; $display("FAIL thr_comb: got %b want 0", afull_o[3]); end
    for (int k = 0; k < 12; k++) rd(2'd3);
    n_tests++; if (cnt_of(3) !== 5'd0) begin n_fail++; $display("FAIL thr_drain: got %0d want 0", cnt_of(3)); end
    afull_thr_i = 5'd16; aempty_thr_i = 5'd0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h300 + i);
    n_tests++; if (cnt_of(0) !== 5'd5) begin n_fail++; $display("FAIL flush_pre: got %0d want 5", cnt_of(0)); end
    flush_i = 4'b0001;
    wr(2'd0, 32'h3FF);
    flush_i = 4'b0000;
    n_tests++; if (cnt_of(0) !== 5'd0 || empty_o[0] !== 1'b1 || full_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_ch0: got c=%0d e=%b f=%b want c=0 e=1 f=0", cnt_of(0), empty_o[0], full_o[0]);
    end
    rd_ch_i = 2'd1;
    #1;
    n_tests++; if (cnt_of(1) !== 5'd1 || rdata_o !== 32'h2AA) begin
      n_fail++; $display("FAIL flush_ch1: got c=%0d d=%h want c=1 d=2aa", cnt_of(1), rdata_o);
    end
    wr(2'd0, 32'h3AB);
    rd_ch_i = 2'd0;
    #1;
    n_tests++; if (rdata_o !== 32'h3AB || cnt_of(0) !== 5'd1) begin
      n_fail++; $display("FAIL flush_after: got d=%h c=%0d want d=3ab c=1", rdata_o, cnt_of(0));
    end
    n_tests++; if ({ovf_o, udf_o} !== 8'h22) begin n_fail++; $display("FAIL flush_noerr: got %h want 22", {ovf_o, udf_o}); end
    clr_err();
    n_tests++; if ({ovf_o, udf_o} !== 8'h00) begin n_fail++; $display("FAIL errclr: got %h want 00", {ovf_o, udf_o}); end
    err_clr_i = 1'b1;
    rd(2'd2);
    err_clr_i = 1'b0;
    n_tests++; if (udf_o !== 4'b0100) begin n_fail++; $display("FAIL errclr_race: got %b want 0100", udf_o); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    wr(2'd1, 32'h555);
    rst = 1'b0;
    n_tests++; if (cnt_o !== 20'h0 || empty_o !== 4'hF) begin
      n_fail++; $display("FAIL rstmid_state: got c=%h e=%h want c=0 e=f", cnt_o, empty_o);
    end
    n_tests++; if ({ovf_o, udf_o} !== 8'h00) begin n_fail++; $display("FAIL rstmid_err: got %h want 00", {ovf_o, udf_o}); end
  endtask

  initial begin
    rst = 1'b1; wren_i = 1'b0; rden_i = 1'b0; err_clr_i = 1'b0;
    wr_ch_i = '0; rd_ch_i = '0; wdata_i = '0; flush_i = '0;
    afull_thr_i = 5'd16; aempty_thr_i = 5'd0;
    test_reset();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_thresholds();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
